// File: rtl/decoder_pkg.sv
// Shared types and helpers for the streaming one-hot decoder.
package decoder_pkg;

    localparam int unsigned MAX_N     = 6;
    localparam int unsigned MAX_OUT_W = 64;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_e;

    // Widest one-hot image of a code; callers truncate to their own width.
    function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_N-1:0] code);
        logic [MAX_OUT_W-1:0] v;
        v       = '0;
        v[code] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/decoder_onehot_stream.sv
// Registered binary-to-one-hot decoder with valid/ready handshake and a
// self-sequencing scan mode driven by a persistent code counter.
module decoder_onehot_stream
    import decoder_pkg::*;
#(
    parameter  int unsigned N     = 2,
    localparam int unsigned OUT_W = 2**N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             in_valid,
    input  logic [N-1:0]     code,
    output logic             in_ready,
    input  logic             scan_en,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out,
    output logic [N-1:0]     out_code,
    output logic             scan_wrap
);

    state_e           r_state;
    logic [N-1:0]     r_code;
    logic [OUT_W-1:0] r_out;
    logic             r_valid;
    logic [N-1:0]     r_cnt;
    logic             r_wrap;

    state_e           w_state_nxt;
    logic [N-1:0]     w_code_nxt;
    logic             w_valid_nxt;
    logic [N-1:0]     w_cnt_nxt;
    logic             w_wrap_nxt;

    logic             w_in_ready;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_scan_go;
    logic             w_last;
    logic [N-1:0]     w_cnt_adv;

    // The slot can refill in the same cycle only when a DIRECT item is leaving.
    assign w_in_ready = ~rst & (mode == MODE_DIRECT)
                      & ((r_state == IDLE) | ((r_state == HOLD) & out_ready));
    assign w_in_fire  = in_valid & w_in_ready;
    assign w_out_fire = r_valid & out_ready;
    assign w_scan_go  = (mode == MODE_SCAN) & scan_en;
    assign w_last     = (r_code == {N{1'b1}});

    // Counter only advances when a scan item is consumed, so it survives pauses.
    assign w_cnt_adv  = ((r_state == SCAN) && w_out_fire) ? r_cnt + N'(1) : r_cnt;

    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_code;
        w_valid_nxt = r_valid;
        w_cnt_nxt   = w_cnt_adv;
        w_wrap_nxt  = (r_state == SCAN) & w_out_fire & w_last;

        case (r_state)
            IDLE: begin
                if (w_in_fire) begin
                    w_state_nxt = HOLD;
                    w_code_nxt  = code;
                    w_valid_nxt = 1'b1;
                end else if (w_scan_go) begin
                    w_state_nxt = SCAN;
                    w_code_nxt  = w_cnt_adv;
                    w_valid_nxt = 1'b1;
                end
            end
            HOLD: begin
                if (w_out_fire) begin
                    if (w_in_fire) begin
                        w_code_nxt = code;
                    end else if (w_scan_go) begin
                        w_state_nxt = SCAN;
                        w_code_nxt  = w_cnt_adv;
                    end else begin
                        w_state_nxt = IDLE;
                        w_valid_nxt = 1'b0;
                    end
                end
            end
            SCAN: begin
                if (w_out_fire) begin
                    if (w_scan_go) begin
                        w_code_nxt = w_cnt_adv;
                    end else begin
                        w_state_nxt = IDLE;
                        w_valid_nxt = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_code  <= '0;
            r_out   <= '0;
            r_valid <= 1'b0;
            r_cnt   <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_code  <= w_code_nxt;
            r_out   <= w_valid_nxt ? OUT_W'(onehot(MAX_N'(w_code_nxt))) : '0;
            r_valid <= w_valid_nxt;
            r_cnt   <= w_cnt_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_valid;
    assign out       = r_out;
    assign out_code  = r_code;
    assign scan_wrap = r_wrap;

endmodule

// File: tb/tb_decoder_onehot_stream.sv
// Randomised and directed bench for decoder_onehot_stream (N=2 and N=3 instances)
// against a transaction-level model of the pending item and scan position.
module tb_decoder_onehot_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       d_mode[2];
    logic       d_in_valid[2];
    logic       d_scan_en[2];
    logic       d_out_ready[2];
    logic [5:0] d_code[2];

    logic [1:0] code0;
    logic [2:0] code1;
    logic       in_ready0, out_valid0, scan_wrap0;
    logic       in_ready1, out_valid1, scan_wrap1;
    logic [3:0] out0;
    logic [7:0] out1;
    logic [1:0] out_code0;
    logic [2:0] out_code1;

    assign code0 = d_code[0][1:0];
    assign code1 = d_code[1][2:0];

    decoder_onehot_stream #(.N(2)) u_dut2 (
        .clk(clk), .rst(rst), .mode(d_mode[0]), .in_valid(d_in_valid[0]),
        .code(code0), .in_ready(in_ready0), .scan_en(d_scan_en[0]),
        .out_ready(d_out_ready[0]), .out_valid(out_valid0), .out(out0),
        .out_code(out_code0), .scan_wrap(scan_wrap0)
    );

    decoder_onehot_stream #(.N(3)) u_dut3 (
        .clk(clk), .rst(rst), .mode(d_mode[1]), .in_valid(d_in_valid[1]),
        .code(code1), .in_ready(in_ready1), .scan_en(d_scan_en[1]),
        .out_ready(d_out_ready[1]), .out_valid(out_valid1), .out(out1),
        .out_code(out_code1), .scan_wrap(scan_wrap1)
    );

    logic [63:0] a_out[2];
    logic [63:0] a_code[2];
    logic        a_valid[2];
    logic        a_ready[2];
    logic        a_wrap[2];

    assign a_out[0]   = 64'(out0);
    assign a_out[1]   = 64'(out1);
    assign a_code[0]  = 64'(out_code0);
    assign a_code[1]  = 64'(out_code1);
    assign a_valid[0] = out_valid0;
    assign a_valid[1] = out_valid1;
    assign a_ready[0] = in_ready0;
    assign a_ready[1] = in_ready1;
    assign a_wrap[0]  = scan_wrap0;
    assign a_wrap[1]  = scan_wrap1;

    // Model: the one pending item (if any), whether it came from the scan
    // counter, the next unsent scan code, and the wrap pulse.
    int          nw[2] = '{2, 3};
    bit          m_valid[2];
    bit          m_scan[2];
    int unsigned m_code[2];
    int unsigned m_cnt[2];
    bit          m_wrap[2];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic set_idle(input int i);
        d_mode[i]      = 1'b0;
        d_in_valid[i]  = 1'b0;
        d_scan_en[i]   = 1'b0;
        d_out_ready[i] = 1'b1;
        d_code[i]      = '0;
    endtask

    task automatic check_outputs(input int i);
        check($sformatf("out_valid[%0d]", i), 64'(a_valid[i]), 64'(m_valid[i]));
        check($sformatf("out[%0d]", i), a_out[i], m_valid[i] ? (64'(1) << m_code[i]) : 64'(0));
        if (m_valid[i])
            check($sformatf("out_code[%0d]", i), a_code[i], 64'(m_code[i]));
        check($sformatf("scan_wrap[%0d]", i), 64'(a_wrap[i]), 64'(m_wrap[i]));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            m_valid[i] = 1'b0; m_scan[i] = 1'b0; m_code[i] = 0;
            m_cnt[i]   = 0;    m_wrap[i] = 1'b0;
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_in_ready[%0d]", i), 64'(a_ready[i]), 64'(0));
            check($sformatf("rst_out_code[%0d]", i), a_code[i], 64'(0));
            check_outputs(i);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_in_ready_hold[%0d]", i), 64'(a_ready[i]), 64'(0));
            check_outputs(i);
        end
        rst = 1'b0;
    endtask

    // One clock: check in_ready against the model, predict, advance, check outputs.
    task automatic tick();
        bit          n_valid[2];
        bit          n_scan[2];
        int unsigned n_code[2];
        int unsigned n_cnt[2];
        bit          n_wrap[2];
        bit          er, in_fire, out_fire;
        int unsigned mx;
        #1;
        for (int i = 0; i < 2; i++) begin
            mx = (1 << nw[i]) - 1;
            er = !rst && !d_mode[i] && (!m_valid[i] || (!m_scan[i] && d_out_ready[i]));
            check($sformatf("in_ready[%0d]", i), 64'(a_ready[i]), 64'(er));
            in_fire  = d_in_valid[i] && er;
            out_fire = m_valid[i] && d_out_ready[i];
            n_wrap[i]  = out_fire && m_scan[i] && (m_code[i] == mx);
            n_cnt[i]   = (out_fire && m_scan[i]) ? ((m_cnt[i] + 1) & mx) : m_cnt[i];
            n_valid[i] = m_valid[i];
            n_scan[i]  = m_scan[i];
            n_code[i]  = m_code[i];
            if (!m_valid[i] || out_fire) begin
                if (in_fire) begin
                    n_valid[i] = 1'b1; n_scan[i] = 1'b0; n_code[i] = d_code[i] & mx;
                end else if (d_mode[i] && d_scan_en[i]) begin
                    n_valid[i] = 1'b1; n_scan[i] = 1'b1; n_code[i] = n_cnt[i];
                end else begin
                    n_valid[i] = 1'b0; n_scan[i] = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            m_valid[i] = n_valid[i]; m_scan[i] = n_scan[i]; m_code[i] = n_code[i];
            m_cnt[i]   = n_cnt[i];   m_wrap[i] = n_wrap[i];
            check_outputs(i);
        end
    endtask

    int seq[6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        set_idle(0);
        set_idle(1);
        #2;
        do_reset();

        // Back-to-back direct codes, one cycle latency, no bubbles.
        for (int c = 0; c < 4; c++) begin
            d_in_valid[0] = 1'b1;
            d_code[0]     = 6'(c);
            tick();
            check("direct_out", a_out[0], 64'(1) << c);
        end
        set_idle(0);
        tick();

        // Backpressure on N=3: code 5 held while input changes to 2.
        d_in_valid[1] = 1'b1;
        d_code[1]     = 6'd5;
        tick();
        check("bp_first", a_out[1], 64'h20);
        d_code[1]      = 6'd2;
        d_out_ready[1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_hold", a_out[1], 64'h20);
        end
        d_out_ready[1] = 1'b1;
        tick();
        check("bp_replace", a_out[1], 64'h04);
        set_idle(1);
        tick();

        // Scan sequence on N=2 with wrap pulse after code 3 is accepted.
        d_mode[0]    = 1'b1;
        d_scan_en[0] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("scan_code", a_code[0], 64'(seq[k]));
            check("scan_wrap_seq", 64'(a_wrap[0]), 64'(k == 4));
        end
        set_idle(0);
        tick();

        // Scan pause after accepting 4, resume at 5, on N=3.
        d_mode[1]    = 1'b1;
        d_scan_en[1] = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        check("pause_at4", a_code[1], 64'd4);
        d_scan_en[1] = 1'b0;
        tick();
        check("pause_idle", 64'(a_valid[1]), 64'(0));
        tick();
        d_scan_en[1] = 1'b1;
        tick();
        check("resume_code", a_code[1], 64'd5);
        set_idle(1);
        tick();

        // Pending direct item survives a mode switch, then scan picks up at cnt=2.
        d_in_valid[0]  = 1'b1;
        d_code[0]      = 6'd1;
        d_out_ready[0] = 1'b0;
        tick();
        d_in_valid[0] = 1'b0;
        d_mode[0]     = 1'b1;
        d_scan_en[0]  = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            check("switch_hold", a_out[0], 64'h2);
        end
        d_out_ready[0] = 1'b1;
        tick();
        check("switch_scan_code", a_code[0], 64'd2);
        tick();
        tick();

        // Reset mid-scan drops the item and restarts the counter at 0.
        do_reset();
        tick();
        check("post_rst_scan", a_code[0], 64'd0);
        set_idle(0);
        tick();

        // Random traffic on both instances.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(0, 7) == 0) d_mode[i] = ~d_mode[i];
                d_in_valid[i]  = ($urandom_range(0, 3) != 0);
                d_scan_en[i]   = ($urandom_range(0, 3) != 0);
                d_out_ready[i] = ($urandom_range(0, 2) != 0);
                d_code[i]      = 6'($urandom);
            end
            if ($urandom_range(0, 499) == 0)
                do_reset();
            else
                tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
